mem_io_target: RTL

//  Memory-side responder for the 6502 core's bus. The core drives the address, write data and write enable.

---
 rtl/mem_io_target.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_io_target.sv
// Bus responder for the 6502 core: RAM, fixed vector bytes and a 16-bit
// interval timer with a level IRQ, all returned through one registered read port.
module mem_io_target #(
    parameter int          RAM_AW    = 11,
    parameter logic [15:0] IO_BASE   = 16'hFE00,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IRQ_VEC   = 16'h0300
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_we,
    output logic [7:0]  o_data,
    output logic        o_irq
);

    localparam logic [2:0] OFF_RLO   = 3'd0;
    localparam logic [2:0] OFF_RHI   = 3'd1;
    localparam logic [2:0] OFF_CTRL  = 3'd2;
    localparam logic [2:0] OFF_STAT  = 3'd3;
    localparam logic [2:0] OFF_CNTLO = 3'd4;
    localparam logic [2:0] OFF_CNTHI = 3'd5;

    logic [7:0]  mem_q [2**RAM_AW];

    logic [7:0]  data_q, data_d;
    logic [7:0]  rlo_q, rlo_d;
    logic [7:0]  rhi_q, rhi_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        os_q, os_d;
    logic        uf_q, uf_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        irq_q, irq_d;

    logic        hit_vec, hit_io, hit_ram;
    logic        io_wr, io_rd;
    logic [2:0]  off;
    logic        underflow;
    logic [7:0]  vec_byte;
    logic [7:0]  rd_data;

    // Vectors shadow everything else, including an IO window placed at the top of memory.
    assign hit_vec   = (i_addr >= 16'hFFFA);
    assign hit_io    = !hit_vec && (i_addr[15:3] == IO_BASE[15:3]);
    assign hit_ram   = !hit_vec && !hit_io && ((i_addr >> RAM_AW) == 16'd0);
    assign off       = i_addr[2:0];
    assign io_wr     = hit_io && i_we;
    assign io_rd     = hit_io && !i_we;
    assign underflow = en_q && (cnt_q == 16'd0);

    always_comb begin
        vec_byte = 8'hFF;
        case (i_addr[2:0])
            3'd2:    vec_byte = IRQ_VEC[7:0];
            3'd3:    vec_byte = IRQ_VEC[15:8];
            3'd4:    vec_byte = RESET_VEC[7:0];
            3'd5:    vec_byte = RESET_VEC[15:8];
            3'd6:    vec_byte = IRQ_VEC[7:0];
            3'd7:    vec_byte = IRQ_VEC[15:8];
            default: vec_byte = 8'hFF;
        endcase
    end

    always_comb begin
        rd_data = 8'hFF;
        if (hit_vec) begin
            rd_data = vec_byte;
        end else if (hit_io) begin
            case (off)
                OFF_RLO:   rd_data = rlo_q;
                OFF_RHI:   rd_data = rhi_q;
                OFF_CTRL:  rd_data = {5'd0, os_q, ie_q, en_q};
                OFF_STAT:  rd_data = {7'd0, uf_q};
                OFF_CNTLO: rd_data = cnt_q[7:0];
                OFF_CNTHI: rd_data = shadow_q;
                default:   rd_data = 8'h00;
            endcase
        end else if (hit_ram) begin
            rd_data = mem_q[i_addr[RAM_AW-1:0]];
        end
    end

    always_comb begin
        data_d   = data_q;
        rlo_d    = rlo_q;
        rhi_d    = rhi_q;
        en_d     = en_q;
        ie_d     = ie_q;
        os_d     = os_q;
        uf_d     = uf_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;

        if (!i_we) begin
            data_d = rd_data;
        end

        if (en_q) begin
            cnt_d = underflow ? {rhi_q, rlo_q} : 16'(cnt_q - 16'd1);
        end

        // A same-edge underflow beats any clear of UF.
        if (underflow) begin
            uf_d = 1'b1;
        end else if ((io_rd && off == OFF_STAT) ||
                     (io_wr && off == OFF_STAT && i_data[0])) begin
            uf_d = 1'b0;
        end

        if (io_wr) begin
            case (off)
                OFF_RLO: rlo_d = i_data;
                OFF_RHI: begin
                    rhi_d = i_data;
                    cnt_d = {i_data, rlo_q};
                end
                OFF_CTRL: begin
                    en_d = i_data[0];
                    ie_d = i_data[1];
                    os_d = i_data[2];
                end
                default: ;
            endcase
        end

        if (underflow && os_q) begin
            en_d = 1'b0;
        end

        if (io_rd && off == OFF_CNTLO) begin
            shadow_d = cnt_q[15:8];
        end

        irq_d = uf_d && ie_d;
    end

    always_ff @(posedge i_clk) begin
        if (hit_ram && i_we) begin
            mem_q[i_addr[RAM_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q   <= 8'hFF;
            rlo_q    <= 8'h00;
            rhi_q    <= 8'h00;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            os_q     <= 1'b0;
            uf_q     <= 1'b0;
            cnt_q    <= 16'h0000;
            shadow_q <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            rlo_q    <= rlo_d;
            rhi_q    <= rhi_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            os_q     <= os_d;
            uf_q     <= uf_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            irq_q    <= irq_d;
        end
    end

    assign o_data = data_q;
    assign o_irq  = irq_q;

endmodule
